imem_stream_loader: RTL

//  Writes programs into instruction memory for the single-cycle core.
//  The core fetches from instruction memory; this block receives a framed byte

---
 rtl/imem_stream_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: receives a framed byte stream (SYNC, LEN_LO, LEN_HI,
// 4*N little-endian data bytes, 8-bit CSUM), writes the assembled 32-bit words
// sequentially into instruction memory and holds the core in reset until a
// complete frame with a matching checksum has been received.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   in_valid   byte available on in_data
//   in_data    stream byte
//   in_ready   always 1 (no backpressure); byte consumed on in_valid & in_ready
//   imem_we    one-cycle IMEM write strobe
//   imem_addr  IMEM byte address (word index * 4), holds last value
//   imem_wdata IMEM write data, holds last value
//   cpu_reset  reset to the core; low only while a good frame is loaded
//   done       frame accepted, core released
//   error      frame rejected (length or checksum)
module imem_stream_loader #(
  parameter int unsigned IMEM_SIZE = 128,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int unsigned LEN_W = 16;
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(IMEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [7:0]       sum;

  logic             accept;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] word_idx_nxt;

  assign accept       = in_valid & in_ready;
  // Word count as it will be once the LEN_HI byte is stored
  assign len_full     = {in_data, len[7:0]};
  assign word_idx_nxt = word_idx + LEN_W'(1);

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      sum        <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      imem_we  <= 1'b0;
      if (accept) begin
        case (state)
          // Outside a frame only SYNC matters; it restarts and re-asserts core reset
          S_IDLE, S_DONE, S_ERR: begin
            if (in_data == SYNC_BYTE) begin
              state     <= S_LEN_LO;
              done      <= 1'b0;
              error     <= 1'b0;
              cpu_reset <= 1'b1;
              sum       <= '0;
              word_idx  <= '0;
              byte_cnt  <= '0;
            end
          end
          S_LEN_LO: begin
            len[7:0] <= in_data;
            state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len[15:8] <= in_data;
            if (len_full > MAX_WORDS) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (len_full == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            sum      <= sum + in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; strobe the write next cycle
                imem_we    <= 1'b1;
                imem_addr  <= 32'(word_idx) << 2;
                imem_wdata <= {in_data, word_buf};
                word_idx   <= word_idx_nxt;
                if (word_idx_nxt == len) begin
                  state <= S_CSUM;
                end
              end
            endcase
          end
          S_CSUM: begin
            if (in_data == sum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
